// File: rtl/nios2e_debug_ocimem_arbiter_pkg.sv
// Shared types and jdo field positions for the OCI RAM arbiter.
package nios2e_debug_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        A_RD = 2'd2
    } state_e;

    typedef enum logic {
        JTAG = 1'b0,
        AVS  = 1'b1
    } grant_e;

    localparam int JDO_W         = 38;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;

    // Round-robin pick between two requesters: a tie goes to whoever was
    // not served last, a lone requester always wins.
    function automatic grant_e rr_pick(input logic req_jtag, input logic req_avs,
                                       input grant_e last_grant);
        grant_e pick;
        if (req_jtag && req_avs) begin
            pick = (last_grant == AVS) ? JTAG : AVS;
        end else if (req_jtag) begin
            pick = JTAG;
        end else begin
            pick = AVS;
        end
        return pick;
    endfunction

endpackage

// File: rtl/nios2e_debug_ocimem_arbiter_if.sv
// Bundle of JTAG command, Avalon slave, RAM and status signals around the arbiter.
interface nios2e_debug_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // JTAG command side
    logic [nios2e_debug_pkg::JDO_W-1:0] jdo;
    logic                               take_action_ocimem_a;
    logic                               take_action_ocimem_b;
    // Avalon debug slave side
    logic [ADDR_W-1:0]                  avs_address;
    logic                               avs_read;
    logic                               avs_write;
    logic [DATA_W-1:0]                  avs_writedata;
    logic [DATA_W-1:0]                  avs_readdata;
    logic                               avs_waitrequest;
    // Single-port RAM side
    logic [ADDR_W-1:0]                  ram_addr;
    logic                               ram_we;
    logic [DATA_W-1:0]                  ram_wdata;
    logic [DATA_W-1:0]                  ram_rdata;
    // Monitor status
    logic [DATA_W-1:0]                  MonDReg;
    logic                               monitor_ready;
    logic                               jtag_overrun;

    // Arbiter view
    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b,
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output MonDReg, monitor_ready, jtag_overrun
    );

    // Environment view (debug logic, CPU and RAM)
    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b,
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  MonDReg, monitor_ready, jtag_overrun
    );
endinterface

// File: rtl/nios2e_debug_ocimem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter remembering the last served requester.
module nios2e_debug_rr_arb2
    import nios2e_debug_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_req_jtag,
    input  logic   i_req_avs,
    input  logic   i_advance,
    output grant_e o_grant,
    output logic   o_any
);
    grant_e r_last_grant;

    assign o_any   = i_req_jtag | i_req_avs;
    assign o_grant = rr_pick(i_req_jtag, i_req_avs, r_last_grant);

    // Record the winner whenever a grant is actually consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= AVS;
        end else if (i_advance && o_any) begin
            r_last_grant <= o_grant;
        end
    end
endmodule

// File: rtl/nios2e_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG monitor commands and the
// CPU-side Avalon debug slave; one grant per IDLE cycle, reads take an extra cycle.
module nios2e_debug_ocimem_arbiter
    import nios2e_debug_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic                          clk,
    input logic                          reset_n,
    nios2e_debug_ocimem_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_jaddr;
    logic              r_jpend;
    logic              r_jwr;
    logic [DATA_W-1:0] r_jwdata;
    logic [DATA_W-1:0] r_mondreg;
    logic              r_overrun;

    logic              w_idle;
    logic              w_jbusy;
    logic              w_avs_req;
    logic              w_any_req;
    logic              w_gnt_jtag;
    logic              w_gnt_avs;
    grant_e            w_grant;

    // Grants are suppressed while reset is held so no RAM write or Avalon
    // accept can leak out during reset.
    assign w_idle     = (r_state == IDLE) && reset_n;
    assign w_jbusy    = r_jpend || (r_state == J_RD);
    assign w_avs_req  = bus.avs_read | bus.avs_write;
    assign w_gnt_jtag = w_idle && w_any_req && (w_grant == JTAG);
    assign w_gnt_avs  = w_idle && w_any_req && (w_grant == AVS);

    nios2e_debug_rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req_jtag (r_jpend),
        .i_req_avs  (w_avs_req),
        .i_advance  (w_idle),
        .o_grant    (w_grant),
        .o_any      (w_any_req)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: reads spend one cycle waiting for RAM data; writes stay in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_jtag && !r_jwr) begin
                    w_state_next = J_RD;
                end else if (w_gnt_avs && !bus.avs_write) begin
                    w_state_next = A_RD;
                end
            end
            J_RD:    w_state_next = IDLE;
            A_RD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: RAM port steering and Avalon handshake.
    always_comb begin
        bus.ram_addr        = r_jaddr;
        bus.ram_we          = 1'b0;
        bus.ram_wdata       = r_jwdata;
        bus.avs_waitrequest = 1'b1;
        bus.avs_readdata    = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_jtag) begin
                    bus.ram_we = r_jwr;
                end else if (w_gnt_avs) begin
                    bus.ram_addr = bus.avs_address;
                    // read+write together is handled as a write
                    if (bus.avs_write) begin
                        bus.ram_we          = 1'b1;
                        bus.ram_wdata       = bus.avs_writedata;
                        bus.avs_waitrequest = 1'b0;
                    end
                end
            end
            A_RD: begin
                bus.avs_readdata    = bus.ram_rdata;
                bus.avs_waitrequest = 1'b0;
            end
            default: ;
        endcase
    end

    // JTAG command capture, completion and the sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jaddr   <= '0;
            r_jpend   <= 1'b0;
            r_jwr     <= 1'b0;
            r_jwdata  <= '0;
            r_mondreg <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_gnt_jtag) begin
                r_jpend <= 1'b0;
                if (r_jwr) begin
                    r_jaddr <= r_jaddr + ADDR_ONE;
                end
            end
            if (r_state == J_RD) begin
                r_mondreg <= bus.ram_rdata;
                r_jaddr   <= r_jaddr + ADDR_ONE;
            end
            // A new pulse cannot collide with the completions above: both
            // only happen while a command is pending or in flight.
            if (bus.take_action_ocimem_a || bus.take_action_ocimem_b) begin
                if (w_jbusy) begin
                    r_overrun <= 1'b1;
                end else if (bus.take_action_ocimem_a) begin
                    r_jaddr <= bus.jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (bus.jdo[JDO_RD_BIT]) begin
                        r_jpend <= 1'b1;
                        r_jwr   <= 1'b0;
                    end
                    if (bus.take_action_ocimem_b) begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_jpend  <= 1'b1;
                    r_jwr    <= 1'b1;
                    r_jwdata <= bus.jdo[JDO_WDATA_LSB +: DATA_W];
                end
            end
        end
    end

    assign bus.MonDReg       = r_mondreg;
    assign bus.monitor_ready = !w_jbusy;
    assign bus.jtag_overrun  = r_overrun;
endmodule

// File: doc/nios2e_debug_ocimem_arbiter.md
Name: nios2e_debug_ocimem_arbiter

Overview:
- Sysclk-domain controller that shares the single-port on-chip debug (OCI) RAM between two requesters: JTAG debug commands (the take_action_ocimem_a/b pulses with jdo from the debug-slave sysclk logic) and the CPU-side Avalon debug slave.
- It sequences JTAG address-load, read and write commands with address auto-increment.
- It returns read data on MonDReg and status on monitor_ready.
- Avalon accesses are stalled with waitrequest while the RAM is busy.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- DATA_W, 32, RAM and MonDReg data width; fixed at 32 for jdo mapping.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data-out word, stable when a take_action pulse is high
- take_action_ocimem_a  in  1  1-cycle pulse: address/read command
- take_action_ocimem_b  in  1  1-cycle pulse: write command
- avs_address  in  ADDR_W  Avalon word address
- avs_read  in  1  Avalon read request
- avs_write  in  1  Avalon write request
- avs_writedata  in  32  Avalon write data
- avs_readdata  out  32  Avalon read data, valid when avs_read && !avs_waitrequest
- avs_waitrequest  out  1  Avalon stall
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, 1-cycle registered latency
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  high when no JTAG command is pending or in flight
- jtag_overrun  out  1  sticky: a JTAG command was dropped

Behaviour:
- Reset values:
  - outputs: MonDReg=0, monitor_ready=1, jtag_overrun=0, ram_we=0, avs_waitrequest=1, avs_readdata=0.
  - internal: jaddr=0, state=IDLE, last_grant=AVS.
- JTAG command decode, on a pulse:
  - ocimem_a with jdo[35]=0: jaddr <= jdo[17 +: ADDR_W]. No RAM access; completes immediately.
  - ocimem_a with jdo[35]=1: jaddr loaded as above, and a read is made pending.
  - ocimem_b: write of jdo[34:3] to jaddr is made pending.
- Pending commands:
  - A pending command clears monitor_ready on the next cycle.
  - A pulse arriving while a JTAG command is pending or in flight is dropped and sets jtag_overrun. jtag_overrun clears only on reset.
- Simultaneous a and b pulses in the same cycle: b is dropped and jtag_overrun is set.
- FSM states: IDLE, J_RD, A_RD.
- IDLE arbitration:
  - Requesters are the JTAG pending flag and avs_read|avs_write.
  - When both request, round-robin against last_grant; a sole requester always wins.
- JTAG write grant:
  - ram_we=1, ram_addr=jaddr, ram_wdata=data for one cycle.
  - Then jaddr <= jaddr+1, monitor_ready=1 next cycle; stay IDLE.
- JTAG read grant:
  - Drive ram_addr=jaddr, go to J_RD.
  - In J_RD: MonDReg <= ram_rdata, jaddr <= jaddr+1, monitor_ready=1, return to IDLE.
- Avalon write grant: ram_we=1 for one cycle, avs_waitrequest=0 in that cycle; stay IDLE.
- Avalon read grant:
  - Go to A_RD with waitrequest held.
  - In A_RD: avs_readdata=ram_rdata, avs_waitrequest=0, return to IDLE.
  - Latency: 2 cycles from grant to accept.
- avs_waitrequest is 1 in every cycle not listed above.
- avs_read and avs_write together: treated as a write.
- Address wrap: jaddr increments modulo 2**ADDR_W (all-ones -> 0).
- Back-to-back grants: one request is granted per IDLE cycle. Worst-case Avalon stall with JTAG contention is 4 cycles.
- Reset mid-operation:
  - In-flight reads are abandoned; no MonDReg update.
  - Pending commands are cleared.

Decomposition:
- Shared package nios2e_debug_pkg:
  - state enum (IDLE, J_RD, A_RD)
  - grant enum (JTAG, AVS)
  - jdo field constants: JDO_RD_BIT=35, JDO_ADDR_LSB=17, JDO_WDATA_LSB=3
- One sub-module: nios2e_debug_rr_arb2, a 2-requester round-robin arbiter with a last_grant register and an advance strobe.

Test Plan:
- Address load: ocimem_a with jdo[35]=0, address 0x10, then ocimem_b with data 0xDEADBEEF -> ram_we at addr 0x10, data 0xDEADBEEF; jaddr becomes 0x11; monitor_ready low for 1 cycle.
- JTAG read: preload RAM[0x20]=0x12345678; ocimem_a with jdo[35]=1, address 0x20 -> MonDReg=0x12345678 two cycles later; monitor_ready returns to 1; jaddr=0x21.
- Wrap: load address 0xFF, then two writes -> RAM[0xFF] and RAM[0x00] written.
- Contention: JTAG write pending and avs_read at 0x05 in the same cycle, last_grant=AVS -> JTAG served first; avs_readdata returned 3 cycles after request; next tie goes to AVS.
- Overrun: ocimem_b pulse while a JTAG read is in J_RD -> command dropped, no extra ram_we, jtag_overrun=1 until reset.
- Reset during A_RD: avs_waitrequest=1 and state=IDLE after deassertion; no spurious ram_we; MonDReg=0.
